// File: rtl/spi_slave.sv
// spi_slave: SPI mode-0 slave, MSB first, oversampled on the system clock
// with a one-entry transmit buffer and strobed receive words.
module spi_slave #(
    parameter int DATA_WIDTH = 8,
    parameter int SYNC_STAGES = 2,
    parameter logic [DATA_WIDTH-1:0] IDLE_WORD = 8'hFF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  sclk,
    input  logic                  ss,
    input  logic                  mosi,
    output logic                  miso,
    output logic                  miso_oe,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    output logic                  busy,
    output logic                  underrun,
    output logic                  abort,
    output logic [31:0]           debug
);
    localparam int CW = $clog2(DATA_WIDTH);

    typedef enum logic {IDLE, ACTIVE} state_t;
    state_t state;

    logic [SYNC_STAGES-1:0] sclk_sync, ss_sync, mosi_sync;
    logic                   prev_sclk, prev_ss;
    logic                   sync_sclk, sync_ss, sync_mosi;
    logic                   rise, fall, ss_fall, ss_rise;
    logic                   active, load, shift;
    logic [DATA_WIDTH-1:0]  tx_shift, rx_shift, tx_buf;
    logic [CW-1:0]          bit_cnt;
    logic                   reload;
    logic [2*DATA_WIDTH+15:0] debug_full;

    assign sync_sclk = sclk_sync[SYNC_STAGES-1];
    assign sync_ss   = ss_sync[SYNC_STAGES-1];
    assign sync_mosi = mosi_sync[SYNC_STAGES-1];
    assign rise      = sync_sclk & ~prev_sclk;
    assign fall      = ~sync_sclk & prev_sclk;
    assign ss_fall   = ~sync_ss & prev_ss;
    assign ss_rise   = sync_ss & ~prev_ss;
    assign active    = state == ACTIVE;

    // ss deassertion outranks any sclk edge seen in the same cycle
    assign load  = (!active && ss_fall) || (active && !ss_rise && fall && reload);
    assign shift = active && !ss_rise && fall && !reload;

    assign miso    = active ? tx_shift[DATA_WIDTH-1] : 1'b1;
    assign miso_oe = active;
    assign busy    = active;

    assign debug_full = {tx_shift, rx_shift, 11'b0, 4'(bit_cnt), active};
    assign debug      = 32'(debug_full);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sclk_sync <= '0;
            ss_sync   <= '1;
            mosi_sync <= '1;
            prev_sclk <= 1'b0;
            prev_ss   <= 1'b1;
            state     <= IDLE;
            tx_shift  <= '0;
            rx_shift  <= '0;
            tx_buf    <= '0;
            tx_ready  <= 1'b1;
            bit_cnt   <= '0;
            reload    <= 1'b0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            underrun  <= 1'b0;
            abort     <= 1'b0;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
            ss_sync   <= {ss_sync[SYNC_STAGES-2:0], ss};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
            prev_sclk <= sync_sclk;
            prev_ss   <= sync_ss;
            rx_valid  <= 1'b0;
            underrun  <= 1'b0;
            abort     <= 1'b0;
            if (tx_valid && tx_ready) begin
                tx_buf   <= tx_data;
                tx_ready <= 1'b0;
            end
            // a reload uses the buffer state from before this cycle's write
            if (load) begin
                if (!tx_ready) begin
                    tx_shift <= tx_buf;
                    tx_ready <= 1'b1;
                end else begin
                    tx_shift <= IDLE_WORD;
                    underrun <= 1'b1;
                end
            end
            if (shift)
                tx_shift <= {tx_shift[DATA_WIDTH-2:0], 1'b0};
            if (!active) begin
                if (ss_fall) begin
                    state   <= ACTIVE;
                    bit_cnt <= '0;
                    reload  <= 1'b0;
                end
            end else if (ss_rise) begin
                state    <= IDLE;
                abort    <= bit_cnt != '0;
                bit_cnt  <= '0;
                rx_shift <= '0;
                reload   <= 1'b0;
            end else begin
                if (fall)
                    reload <= 1'b0;
                if (rise) begin
                    rx_shift <= {rx_shift[DATA_WIDTH-2:0], sync_mosi};
                    if (bit_cnt == CW'(DATA_WIDTH - 1)) begin
                        rx_data  <= {rx_shift[DATA_WIDTH-2:0], sync_mosi};
                        rx_valid <= 1'b1;
                        bit_cnt  <= '0;
                        reload   <= 1'b1;
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_spi_slave.sv
// tb_spi_slave: directed SPI master stimulus with a receive-word scoreboard
// and pulse counters for underrun/abort.
module tb_spi_slave;
    localparam int H = 4;

    logic        clk = 1'b0;
    logic        rst, sclk, ss, mosi, tx_valid;
    logic [7:0]  tx_data;
    logic        miso, miso_oe, tx_ready, rx_valid, busy, underrun, abort;
    logic [7:0]  rx_data;
    logic [31:0] debug;

    spi_slave dut (
        .clk(clk), .rst(rst), .sclk(sclk), .ss(ss), .mosi(mosi),
        .miso(miso), .miso_oe(miso_oe), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid), .busy(busy),
        .underrun(underrun), .abort(abort), .debug(debug)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_err = 0;
    int rx_cnt = 0, un_cnt = 0, ab_cnt = 0;
    logic [7:0] exp_rx[$];
    logic [7:0] mo[3], mi[3];
    logic       inj_en = 1'b0;
    logic [7:0] inj_word = 8'h00;
    int         rx0, un0, ab0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // scoreboard monitor: every rx_valid strobe must match the oldest word sent
    always @(negedge clk) begin
        if (rst) begin
            if (rx_valid) begin
                rx_cnt++;
                if (exp_rx.size() == 0) chk("rx_unexpected", {24'h0, rx_data}, 32'hFFFF_FFFF);
                else chk("rx_word", {24'h0, rx_data}, {24'h0, exp_rx.pop_front()});
            end
            if (underrun) un_cnt++;
            if (abort) ab_cnt++;
        end
    end

    task automatic tx_write(input logic [7:0] w);
        @(negedge clk);
        tx_data  = w;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
    endtask

    // n words with ss held low; stop>0 returns right after that many rises
    task automatic spi_xfer(input int n, input int stop);
        int rises = 0;
        ss   = 1'b0;
        sclk = 1'b0;
        for (int w = 0; w < n; w++) begin
            for (int b = 7; b >= 0; b--) begin
                mosi = mo[w][b];
                if (inj_en && w == 1 && b == 7) begin
                    repeat (2) @(negedge clk);
                    tx_data  = inj_word;
                    tx_valid = 1'b1;
                    @(negedge clk);
                    tx_valid = 1'b0;
                    repeat (H - 3) @(negedge clk);
                end else begin
                    repeat (H) @(negedge clk);
                end
                if (b == 7) chk("miso_oe_active", {31'h0, miso_oe}, 32'h1);
                mi[w][b] = miso;
                if (b == 0) exp_rx.push_back(mo[w]);
                sclk = 1'b1;
                rises++;
                if (rises == stop) return;
                repeat (H) @(negedge clk);
                sclk = 1'b0;
                if (w == n - 1 && b == 0) ss = 1'b1;
            end
        end
        mosi = 1'b1;
        repeat (2 * H) @(negedge clk);
    endtask

    task automatic snap;
        rx0 = rx_cnt;
        un0 = un_cnt;
        ab0 = ab_cnt;
    endtask

    initial begin
        rst = 1'b0; sclk = 1'b0; ss = 1'b1; mosi = 1'b1;
        tx_valid = 1'b0; tx_data = 8'h00;
        repeat (3) @(negedge clk);
        chk("rst_miso", {31'h0, miso}, 32'h1);
        chk("rst_miso_oe", {31'h0, miso_oe}, 32'h0);
        chk("rst_tx_ready", {31'h0, tx_ready}, 32'h1);
        chk("rst_rx_data", {24'h0, rx_data}, 32'h0);
        chk("rst_strobes", {28'h0, rx_valid, busy, underrun, abort}, 32'h0);
        chk("rst_debug", debug, 32'h0);
        rst = 1'b1;
        repeat (4) @(negedge clk);

        // single word with buffered transmit data
        snap();
        tx_write(8'hA5);
        chk("tx_ready_full", {31'h0, tx_ready}, 32'h0);
        mo[0] = 8'h3C;
        spi_xfer(1, 0);
        chk("single_miso_word", {24'h0, mi[0]}, 32'hA5);
        chk("single_rx_count", rx_cnt - rx0, 1);
        chk("single_rx_data", {24'h0, rx_data}, 32'h3C);
        chk("single_tx_ready", {31'h0, tx_ready}, 32'h1);
        chk("single_no_underrun", un_cnt - un0, 0);
        chk("idle_miso_oe", {31'h0, miso_oe}, 32'h0);

        // underrun
        snap();
        mo[0] = 8'h81;
        spi_xfer(1, 0);
        chk("underrun_miso_word", {24'h0, mi[0]}, 32'hFF);
        chk("underrun_count", un_cnt - un0, 1);
        chk("underrun_rx_data", {24'h0, rx_data}, 32'h81);

        // burst of two words, second buffered mid-word
        snap();
        tx_write(8'h11);
        mo[0] = 8'hDE;
        mo[1] = 8'hAD;
        fork
            spi_xfer(2, 0);
            begin
                repeat (20) @(negedge clk);
                chk("burst_tx_ready_mid", {31'h0, tx_ready}, 32'h1);
                tx_write(8'h22);
            end
        join
        chk("burst_miso_w0", {24'h0, mi[0]}, 32'h11);
        chk("burst_miso_w1", {24'h0, mi[1]}, 32'h22);
        chk("burst_rx_count", rx_cnt - rx0, 2);
        chk("burst_no_underrun", un_cnt - un0, 0);

        // abort after five rises
        snap();
        mo[0] = 8'hF0;
        spi_xfer(1, 5);
        repeat (H) @(negedge clk);
        sclk = 1'b0;
        ss   = 1'b1;
        mosi = 1'b1;
        repeat (2 * H) @(negedge clk);
        chk("abort_count", ab_cnt - ab0, 1);
        chk("abort_no_rx", rx_cnt - rx0, 0);
        chk("abort_miso_oe", {31'h0, miso_oe}, 32'h0);
        chk("abort_rx_data_held", {24'h0, rx_data}, 32'hAD);
        mo[0] = 8'h6B;
        spi_xfer(1, 0);
        chk("post_abort_rx_data", {24'h0, rx_data}, 32'h6B);
        chk("post_abort_miso", {24'h0, mi[0]}, 32'hFF);
        chk("post_abort_no_abort", ab_cnt - ab0, 1);

        // write landing on the reload cycle
        snap();
        tx_write(8'h96);
        mo[0] = 8'h01; mo[1] = 8'h02; mo[2] = 8'h03;
        inj_en   = 1'b1;
        inj_word = 8'h5A;
        spi_xfer(3, 0);
        inj_en = 1'b0;
        chk("sim_miso_w0", {24'h0, mi[0]}, 32'h96);
        chk("sim_miso_w1", {24'h0, mi[1]}, 32'hFF);
        chk("sim_miso_w2", {24'h0, mi[2]}, 32'h5A);
        chk("sim_underrun", un_cnt - un0, 1);
        chk("sim_tx_ready", {31'h0, tx_ready}, 32'h1);

        // asynchronous reset at bit 3
        snap();
        mo[0] = 8'hE7;
        spi_xfer(1, 3);
        tx_write(8'h77);
        @(negedge clk);
        chk("pre_rst_tx_ready", {31'h0, tx_ready}, 32'h0);
        chk("pre_rst_bit_cnt", {27'h0, debug[4:0]}, 32'h7);
        #2 rst = 1'b0;
        #1;
        chk("async_rst_miso", {31'h0, miso}, 32'h1);
        chk("async_rst_outs", {28'h0, miso_oe, busy, rx_valid, abort}, 32'h0);
        chk("async_rst_tx_ready", {31'h0, tx_ready}, 32'h1);
        chk("async_rst_rx_data", {24'h0, rx_data}, 32'h0);
        chk("async_rst_debug", debug, 32'h0);
        exp_rx.delete();
        @(negedge clk);
        sclk = 1'b0;
        ss   = 1'b1;
        mosi = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (4) @(negedge clk);
        snap();
        tx_write(8'hC3);
        mo[0] = 8'hC3;
        spi_xfer(1, 0);
        chk("post_rst_miso", {24'h0, mi[0]}, 32'hC3);
        chk("post_rst_rx_data", {24'h0, rx_data}, 32'hC3);
        chk("post_rst_rx_count", rx_cnt - rx0, 1);

        repeat (4) @(negedge clk);
        chk("rx_queue_empty", exp_rx.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
